// File: rtl/ad1pmod_sample_ctrl_if.sv
// Sample-pair handshake between the AD1 Pmod sequencer and its consumer
// (the AXI4-Lite register slave). A pair transfers on valid && ready.
interface ad1pmod_sample_ctrl_if;
   logic        sample_valid;
   logic        sample_ready;
   logic [11:0] sample_ch0;
   logic [11:0] sample_ch1;

   modport master (
      output sample_valid,
      output sample_ch0,
      output sample_ch1,
      input  sample_ready
   );

   modport slave (
      input  sample_valid,
      input  sample_ch0,
      input  sample_ch1,
      output sample_ready
   );
endinterface

// File: rtl/ad1pmod_sample_ctrl.sv
// Conversion sequencer for the dual-channel AD1 Pmod (two AD7476A sharing
// CS and SCLK). Generates CS/SCLK, shifts both SDATA lines in parallel,
// paces conversions from a period timer or a one-shot request and presents
// each 12-bit pair on a valid/ready handshake.
// Optional feature: define AD1PMOD_FRAME_CHECK_EN to require the 4 leading
// bits of every frame to be zero; offending frames raise frame_err and are
// not delivered. Without the macro the leading bits are ignored.
module ad1pmod_sample_ctrl #(
   parameter int CLK_DIV  = 4,   // ACLK cycles per SCLK half-period (>=2)
   parameter int QUIET    = 8,   // ACLK cycles CS stays high after a frame (>=1)
   parameter int PERIOD_W = 16
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                cfg_enable,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic                cfg_oneshot,
   input  logic                overrun_clr,
   output logic                pmod_cs_n,
   output logic                pmod_sclk,
   input  logic                pmod_sdata0,
   input  logic                pmod_sdata1,
   ad1pmod_sample_ctrl_if.master smp,
   output logic                busy,
   output logic                overrun,
   output logic                trig_miss,
   output logic                frame_err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_QUIET = 2'd3;

   localparam int CNT_MAX = (CLK_DIV > QUIET) ? CLK_DIV : QUIET;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   logic frame_bad;

`ifdef AD1PMOD_FRAME_CHECK_EN
   // Full 16-bit frames are kept so the leading bits can be inspected.
   localparam int SH_W = 16;
`else
   // Only the 12 data bits are kept; the leading bits simply shift out.
   localparam int SH_W = 12;
`endif

   logic [1:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [3:0]          bit_q, bit_d;
   logic                sclk_q, sclk_d;
   logic                cs_n_q, cs_n_d;
   logic                busy_q, busy_d;
   logic [SH_W-1:0]     sh0_q, sh0_d;
   logic [SH_W-1:0]     sh1_q, sh1_d;
   logic [PERIOD_W-1:0] timer_q, timer_d;
   logic                valid_q, valid_d;
   logic [11:0]         ch0_q, ch0_d;
   logic [11:0]         ch1_q, ch1_d;
   logic                overrun_q, overrun_d;
   logic                trig_miss_q, trig_miss_d;

   logic trig;
   logic start;
   logic frame_done;
   logic load;
   logic xfer;

   // Periodic trigger fires at terminal count; one-shot and trigger together
   // still make a single start.
   assign trig  = cfg_enable && (timer_q == cfg_period);
   assign start = trig || cfg_oneshot;
   assign load  = frame_done && !frame_bad;
   assign xfer  = valid_q && smp.sample_ready;

   // Period timer: counts 0..cfg_period while enabled, held at 0 otherwise.
   always_comb begin
      if (!cfg_enable || trig) timer_d = '0;
      else                     timer_d = timer_q + PERIOD_W'(1);
   end

   // Frame sequencer: CS/SCLK generation and parallel SDATA capture.
   always_comb begin
      // NOTE: every next-state signal gets a default first, so no path leaves
      // one unassigned and no latch is inferred.
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      sclk_d     = sclk_q;
      cs_n_d     = cs_n_q;
      busy_d     = busy_q;
      sh0_d      = sh0_q;
      sh1_d      = sh1_q;
      frame_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SETUP;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = '0;
            end
         end
         ST_SETUP: begin
            if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
               sclk_d  = 1'b0;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_SHIFT: begin
            if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
               cnt_d = '0;
               if (!sclk_q) begin
                  // Rising SCLK edge: capture both lines, MSB first.
                  sclk_d = 1'b1;
                  sh0_d  = {sh0_q[SH_W-2:0], pmod_sdata0};
                  sh1_d  = {sh1_q[SH_W-2:0], pmod_sdata1};
               end else if (bit_q == 4'd15) begin
                  state_d    = ST_QUIET;
                  cs_n_d     = 1'b1;
                  frame_done = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  bit_d  = bit_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_QUIET: begin
            if (cnt_q == CNT_W'(QUIET - 1)) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output pair, handshake and sticky flags; a set event beats a clear.
   always_comb begin
      valid_d     = valid_q;
      ch0_d       = ch0_q;
      ch1_d       = ch1_q;
      overrun_d   = overrun_q;
      trig_miss_d = trig_miss_q;
      if (overrun_clr) begin
         overrun_d   = 1'b0;
         trig_miss_d = 1'b0;
      end
      if (xfer) valid_d = 1'b0;
      if (load) begin
         valid_d = 1'b1;
         ch0_d   = sh0_q[11:0];
         ch1_d   = sh1_q[11:0];
         if (valid_q && !xfer) overrun_d = 1'b1;
      end
      if (trig && (state_q != ST_IDLE)) trig_miss_d = 1'b1;
   end

   // State registers with synchronous reset; a reset mid-frame drops it.
   always_ff @(posedge ACLK) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (ARESET) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         sclk_q      <= 1'b1;
         cs_n_q      <= 1'b1;
         busy_q      <= 1'b0;
         sh0_q       <= '0;
         sh1_q       <= '0;
         timer_q     <= '0;
         valid_q     <= 1'b0;
         ch0_q       <= '0;
         ch1_q       <= '0;
         overrun_q   <= 1'b0;
         trig_miss_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         sclk_q      <= sclk_d;
         cs_n_q      <= cs_n_d;
         busy_q      <= busy_d;
         sh0_q       <= sh0_d;
         sh1_q       <= sh1_d;
         timer_q     <= timer_d;
         valid_q     <= valid_d;
         ch0_q       <= ch0_d;
         ch1_q       <= ch1_d;
         overrun_q   <= overrun_d;
         trig_miss_q <= trig_miss_d;
      end
   end

`ifdef AD1PMOD_FRAME_CHECK_EN
   logic frame_err_q;

   assign frame_bad = (sh0_q[15:12] != 4'd0) || (sh1_q[15:12] != 4'd0);

   // Sticky frame-error flag; a bad frame in the same cycle beats a clear.
   always_ff @(posedge ACLK) begin
      if (ARESET)                       frame_err_q <= 1'b0;
      else if (frame_done && frame_bad) frame_err_q <= 1'b1;
      else if (overrun_clr)             frame_err_q <= 1'b0;
   end

   assign frame_err = frame_err_q;
`else
   assign frame_bad = 1'b0;
   assign frame_err = 1'b0;
`endif

   assign pmod_cs_n        = cs_n_q;
   assign pmod_sclk        = sclk_q;
   assign busy             = busy_q;
   assign overrun          = overrun_q;
   assign trig_miss        = trig_miss_q;
   assign smp.sample_valid = valid_q;
   assign smp.sample_ch0   = ch0_q;
   assign smp.sample_ch1   = ch1_q;

endmodule

// File: tb/tb_ad1pmod_sample_ctrl.sv
// Directed bench for ad1pmod_sample_ctrl: frame timing, a table of data
// frames, periodic pacing, trigger miss, overrun and reset mid-frame.
module tb_ad1pmod_sample_ctrl;

   localparam int CD = 4;
   localparam int QT = 8;

`ifdef AD1PMOD_FRAME_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        ARESET;
   logic        cfg_enable;
   logic [15:0] cfg_period;
   logic        cfg_oneshot;
   logic        overrun_clr;
   logic        pmod_cs_n;
   logic        pmod_sclk;
   logic        sdata0;
   logic        sdata1;
   logic        busy;
   logic        overrun;
   logic        trig_miss;
   logic        frame_err;

   ad1pmod_sample_ctrl_if smp_if ();

   ad1pmod_sample_ctrl #(.CLK_DIV(CD), .QUIET(QT), .PERIOD_W(16)) dut (
      .ACLK        (clk),
      .ARESET      (ARESET),
      .cfg_enable  (cfg_enable),
      .cfg_period  (cfg_period),
      .cfg_oneshot (cfg_oneshot),
      .overrun_clr (overrun_clr),
      .pmod_cs_n   (pmod_cs_n),
      .pmod_sclk   (pmod_sclk),
      .pmod_sdata0 (sdata0),
      .pmod_sdata1 (sdata1),
      .smp         (smp_if.master),
      .busy        (busy),
      .overrun     (overrun),
      .trig_miss   (trig_miss),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Converter model: presents the next frame bit after each SCLK fall.
   logic [15:0] tx0 = 16'h0;
   logic [15:0] tx1 = 16'h0;
   int          bit_idx = 0;

   always @(negedge pmod_cs_n) bit_idx = 0;

   always @(negedge pmod_sclk) begin
      if (bit_idx < 16) begin
         sdata0 = tx0[15 - bit_idx];
         sdata1 = tx1[15 - bit_idx];
         bit_idx++;
      end
   end

   task automatic run_frame(input logic [15:0] d0, input logic [15:0] d1);
      int n;
      tx0 = d0;
      tx1 = d1;
      @(negedge clk); cfg_oneshot = 1'b1;
      @(negedge clk); cfg_oneshot = 1'b0;
      n = 0;
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("frame_completes", 32'(n < 400), 32'd1);
   endtask

   task automatic consume();
      @(negedge clk); smp_if.sample_ready = 1'b1;
      @(negedge clk); smp_if.sample_ready = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle", 32'(n < 400), 32'd1);
   endtask

   // Records CS falling edges (cycle index) over a window of cycles.
   task automatic watch_cs(input int ncyc, output int falls[$]);
      logic prev;
      falls = {};
      prev  = pmod_cs_n;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (prev && !pmod_cs_n) falls.push_back(c);
         prev = pmod_cs_n;
      end
   endtask

   typedef struct {
      logic [15:0] d0;
      logic [15:0] d1;
      logic [11:0] e0;
      logic [11:0] e1;
   } vec_t;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[5];
      int          falls[$];
      logic [11:0] exp_ch0, exp_ch1;
      logic        exp_err, bad;

      vecs[0] = '{16'h0ABC, 16'h0123, 12'hABC, 12'h123};
      vecs[1] = '{16'h0FFF, 16'h0000, 12'hFFF, 12'h000};
      vecs[2] = '{16'h0555, 16'h0AAA, 12'h555, 12'hAAA};
      vecs[3] = '{16'h0001, 16'h0800, 12'h001, 12'h800};
      vecs[4] = '{16'h8ABC, 16'h0123, 12'hABC, 12'h123};

      ARESET = 1'b1;
      cfg_enable = 1'b0;
      cfg_period = 16'd0;
      cfg_oneshot = 1'b0;
      overrun_clr = 1'b0;
      smp_if.sample_ready = 1'b0;
      sdata0 = 1'b0;
      sdata1 = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      check("rst_cs_n", pmod_cs_n, 1);
      check("rst_sclk", pmod_sclk, 1);
      check("rst_valid", smp_if.sample_valid, 0);
      check("rst_ch0", smp_if.sample_ch0, 0);
      check("rst_ch1", smp_if.sample_ch1, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_trig_miss", trig_miss, 0);
      check("rst_frame_err", frame_err, 0);
      @(negedge clk); ARESET = 1'b0;
      repeat (2) @(negedge clk);

      // Single frame timing relative to the start cycle T
      tx0 = 16'h0ABC;
      tx1 = 16'h0123;
      cfg_oneshot = 1'b1;
      for (int c = 1; c <= 1 + 33*CD + QT; c++) begin
         @(negedge clk);
         cfg_oneshot = 1'b0;
         if (c == 1) begin
            check("t1_cs_low", pmod_cs_n, 0);
            check("t1_busy", busy, 1);
         end
         if (c == CD)            check("t1_sclk_setup_high", pmod_sclk, 1);
         if (c == 1 + CD)        check("t1_sclk_first_fall", pmod_sclk, 0);
         if (c == 32*CD)         check("t1_cs_last_low", pmod_cs_n, 0);
         if (c == 32*CD)         check("t1_valid_not_yet", smp_if.sample_valid, 0);
         if (c == 1 + 33*CD) begin
            check("t1_cs_high", pmod_cs_n, 1);
            check("t1_valid", smp_if.sample_valid, 1);
            check("t1_ch0", smp_if.sample_ch0, 12'hABC);
            check("t1_ch1", smp_if.sample_ch1, 12'h123);
         end
         if (c == 33*CD + QT)    check("t1_busy_quiet", busy, 1);
         if (c == 1 + 33*CD + QT) check("t1_busy_done", busy, 0);
      end
      consume();
      check("t1_valid_consumed", smp_if.sample_valid, 0);

      // Table of data frames, each consumed before the next
      exp_ch0 = 12'hABC;
      exp_ch1 = 12'h123;
      exp_err = 1'b0;
      for (int i = 0; i < 5; i++) begin
         run_frame(vecs[i].d0, vecs[i].d1);
         bad = (vecs[i].d0[15:12] != 4'd0) || (vecs[i].d1[15:12] != 4'd0);
         if (CHK && bad) begin
            exp_err = 1'b1;
            check($sformatf("vec%0d_valid", i), smp_if.sample_valid, 0);
         end else begin
            exp_ch0 = vecs[i].e0;
            exp_ch1 = vecs[i].e1;
            check($sformatf("vec%0d_valid", i), smp_if.sample_valid, 1);
         end
         check($sformatf("vec%0d_ch0", i), smp_if.sample_ch0, exp_ch0);
         check($sformatf("vec%0d_ch1", i), smp_if.sample_ch1, exp_ch1);
         check($sformatf("vec%0d_frame_err", i), frame_err, exp_err);
         consume();
      end
      @(negedge clk); overrun_clr = 1'b1;
      @(negedge clk); overrun_clr = 1'b0;

      // Periodic pacing, period 200 cycles, consumer always ready
      tx0 = 16'h0321;
      tx1 = 16'h0654;
      smp_if.sample_ready = 1'b1;
      cfg_period = 16'd199;
      cfg_enable = 1'b1;
      watch_cs(1150, falls);
      check("per_nframes", 32'(falls.size() >= 5), 1);
      for (int i = 1; i < 5; i++)
         if (i < falls.size())
            check($sformatf("per_gap%0d", i), falls[i] - falls[i-1], 200);
      check("per_trig_miss", trig_miss, 0);
      check("per_overrun", overrun, 0);
      check("per_ch0", smp_if.sample_ch0, 12'h321);
      check("per_ch1", smp_if.sample_ch1, 12'h654);
      cfg_enable = 1'b0;
      wait_idle();

      // Period shorter than a frame: every other trigger is missed
      @(negedge clk);
      cfg_period = 16'd99;
      cfg_enable = 1'b1;
      watch_cs(650, falls);
      check("miss_flag", trig_miss, 1);
      check("miss_nframes", 32'(falls.size() >= 3), 1);
      for (int i = 1; i < 3; i++)
         if (i < falls.size())
            check($sformatf("miss_gap%0d", i), falls[i] - falls[i-1], 200);
      cfg_enable = 1'b0;
      wait_idle();
      check("miss_ch0", smp_if.sample_ch0, 12'h321);
      @(negedge clk); overrun_clr = 1'b1;
      @(negedge clk); overrun_clr = 1'b0;
      check("miss_cleared", trig_miss, 0);
      smp_if.sample_ready = 1'b0;
      @(negedge clk);

      // Overrun: two frames 150 cycles apart with no consumer
      tx0 = 16'h0111;
      tx1 = 16'h0011;
      @(negedge clk); cfg_oneshot = 1'b1;
      @(negedge clk); cfg_oneshot = 1'b0;
      repeat (148) @(negedge clk);
      check("ovr_first_valid", smp_if.sample_valid, 1);
      check("ovr_first_ch0", smp_if.sample_ch0, 12'h111);
      check("ovr_first_flag", overrun, 0);
      tx0 = 16'h0222;
      tx1 = 16'h0022;
      @(negedge clk); cfg_oneshot = 1'b1;
      @(negedge clk); cfg_oneshot = 1'b0;
      wait_idle();
      check("ovr_flag", overrun, 1);
      check("ovr_ch0", smp_if.sample_ch0, 12'h222);
      check("ovr_ch1", smp_if.sample_ch1, 12'h022);
      check("ovr_valid_held", smp_if.sample_valid, 1);
      consume();
      check("ovr_valid_after_ready", smp_if.sample_valid, 0);
      @(negedge clk); overrun_clr = 1'b1;
      @(negedge clk); overrun_clr = 1'b0;
      check("ovr_cleared", overrun, 0);

      // Reset in the middle of SHIFT, then a clean frame
      tx0 = 16'h0FFF;
      tx1 = 16'h0FFF;
      @(negedge clk); cfg_oneshot = 1'b1;
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         cfg_oneshot = 1'b0;
      end
      check("rstmid_in_frame", pmod_cs_n, 0);
      ARESET = 1'b1;
      @(negedge clk);
      check("rstmid_cs_n", pmod_cs_n, 1);
      check("rstmid_sclk", pmod_sclk, 1);
      check("rstmid_busy", busy, 0);
      check("rstmid_valid", smp_if.sample_valid, 0);
      ARESET = 1'b0;
      @(negedge clk);
      run_frame(16'h0A5A, 16'h05A5);
      check("rstmid_next_valid", smp_if.sample_valid, 1);
      check("rstmid_next_ch0", smp_if.sample_ch0, 12'hA5A);
      check("rstmid_next_ch1", smp_if.sample_ch1, 12'h5A5);
      check("rstmid_next_err", frame_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
